// File: rtl/bin_to_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_converter
//  Description : Sequential double-dabble binary-to-BCD converter with
//                valid/ready input handshake, completion strobe, leading-zero
//                blanking mask and overflow saturation to all nines.
//  Revision    : 1.0  initial release
// ============================================================================
module bin_to_bcd_converter #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_BITS   = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_BITS-1:0]     bin_in,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic                    out_valid,
    output logic                    overflow
);

    localparam int SCR_W = 4 * NUM_DIGITS;
    localparam int TOT_W = SCR_W + BIN_BITS;
    localparam int CNT_W = (BIN_BITS > 1) ? $clog2(BIN_BITS) : 1;

    localparam logic [CNT_W-1:0]      C_LAST_ITER = CNT_W'(BIN_BITS - 1);
    localparam logic [SCR_W-1:0]      C_ALL_NINES = {NUM_DIGITS{4'h9}};
    // Reset / zero display: every digit blanked except the units digit
    localparam logic [NUM_DIGITS-1:0] C_BLANK_RST = {NUM_DIGITS{1'b1}} << 1;

    // 10**NUM_DIGITS evaluated at elaboration in 64-bit arithmetic
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] C_LIMIT = pow10(NUM_DIGITS);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              r_state;
    logic [SCR_W-1:0]    r_scratch;
    logic [BIN_BITS-1:0] r_shift;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf_pend;

    logic [SCR_W-1:0]      w_adj;
    logic [TOT_W-1:0]      w_cat_sh;
    logic [SCR_W-1:0]      w_next_scratch;
    logic [BIN_BITS-1:0]   w_next_shift;
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_zero_run;
    logic                  w_ovf_in;

    assign in_ready = (r_state == IDLE);

    // Values that cannot reach the limit (small BIN_BITS) make this constant 0
    assign w_ovf_in = ({{(64-BIN_BITS){1'b0}}, bin_in} >= C_LIMIT);

    // Per-nibble add-3 correction; nibbles are independent, no carry between them
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        assign w_adj[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5) ?
                                 (r_scratch[4*g +: 4] + 4'd3) : r_scratch[4*g +: 4];
    end

    // Scratch and shift register move left together as one vector
    assign w_cat_sh       = {w_adj, r_shift} << 1;
    assign w_next_scratch = w_cat_sh[TOT_W-1 -: SCR_W];
    assign w_next_shift   = w_cat_sh[BIN_BITS-1:0];

    // Leading-zero mask of the result being completed this cycle
    always_comb begin
        w_zero_run = 1'b1;
        w_blank    = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_run = w_zero_run & (w_next_scratch[4*i +: 4] == 4'd0);
            w_blank[i] = w_zero_run;
        end
    end

    // Control FSM, datapath registers and registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_scratch  <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            bcd_out    <= '0;
            blank_out  <= C_BLANK_RST;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift    <= bin_in;
                        r_scratch  <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= w_ovf_in;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_next_scratch;
                    r_shift   <= w_next_shift;
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST_ITER) begin
                        out_valid <= 1'b1;
                        overflow  <= r_ovf_pend;
                        r_state   <= IDLE;
                        if (r_ovf_pend) begin
                            bcd_out   <= C_ALL_NINES;
                            blank_out <= '0;
                        end else begin
                            bcd_out   <= w_next_scratch;
                            blank_out <= w_blank;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_bcd_converter
//  Description : Scoreboard bench for bin_to_bcd_converter (4-digit/14-bit
//                main instance plus a 1-digit/4-bit instance).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bin_to_bcd_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Main instance: NUM_DIGITS=4, BIN_BITS=14
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [13:0] bin_in = '0;
    logic [15:0] bcd_out;
    logic [3:0]  blank_out;
    logic        out_valid;
    logic        overflow;

    // Small instance: NUM_DIGITS=1, BIN_BITS=4
    logic        iv2 = 1'b0;
    logic        rdy2;
    logic [3:0]  bin2 = '0;
    logic [3:0]  bcd2;
    logic [0:0]  blank2;
    logic        ov2;
    logic        ovf2;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  blank;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t q2[$];

    int checks   = 0;
    int failures = 0;
    int pcyc     = 0;
    int lowcnt   = 0;

    bin_to_bcd_converter #(.NUM_DIGITS(4), .BIN_BITS(14)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .bin_in(bin_in), .bcd_out(bcd_out), .blank_out(blank_out),
        .out_valid(out_valid), .overflow(overflow)
    );

    bin_to_bcd_converter #(.NUM_DIGITS(1), .BIN_BITS(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2),
        .bin_in(bin2), .bcd_out(bcd2), .blank_out(blank2),
        .out_valid(ov2), .overflow(ovf2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Independent reference: decimal digits by division, saturate on overflow
    function automatic exp_t model(input int v);
        exp_t e;
        logic zr;
        e.ovf = (v >= 10000);
        for (int i = 0, p = 1; i < 4; i++, p = p * 10)
            e.bcd[4*i +: 4] = 4'((v / p) % 10);
        e.blank = 4'b0000;
        zr = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            zr = zr & (e.bcd[4*i +: 4] == 4'd0);
            e.blank[i] = zr;
        end
        if (e.ovf) begin
            e.bcd   = 16'h9999;
            e.blank = 4'b0000;
        end
        e.due = 0;
        return e;
    endfunction

    // Main monitor: pops on every out_valid, also checks in_ready low window
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            lowcnt = 0;
        end else if (!in_ready) begin
            lowcnt++;
        end else if (lowcnt != 0) begin
            chk("in_ready_low_cycles", lowcnt, 14);
            lowcnt = 0;
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("bcd_out", bcd_out, e.bcd);
                chk("blank_out", blank_out, e.blank);
                chk("overflow", overflow, e.ovf);
                chk("latency", pcyc, e.due);
                chk("in_ready_with_strobe", in_ready, 1);
            end
        end
    end

    // Small-instance monitor
    always @(negedge clk) begin
        exp_t e;
        if (ov2) begin
            if (q2.size() == 0) begin
                chk("unexpected_out_valid2", 1, 0);
            end else begin
                e = q2.pop_front();
                chk("bcd2", bcd2, e.bcd[3:0]);
                chk("blank2", blank2, e.blank[0]);
                chk("overflow2", ovf2, e.ovf);
                chk("latency2", pcyc, e.due);
            end
        end
    end

    // Present v (junk on bin_in until the accept edge), push expectation at accept
    task automatic send(input int v, input logic [15:0] eb, input logic [3:0] ebl,
                        input logic eo, input logic keep);
        exp_t e;
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        bin_in   = 14'h3fff;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 1, 0);
        bin_in = 14'(v);
        e.bcd = eb; e.blank = ebl; e.ovf = eo; e.due = pcyc + 15;
        q.push_back(e);
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
        bin_in = 14'h3fff;
    endtask

    task automatic send2(input int v);
        exp_t e;
        bit ok;
        ok = 0;
        iv2  = 1'b1;
        bin2 = 4'(v);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy2) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout2", 1, 0);
        e.bcd = {12'h0, (v >= 10) ? 4'h9 : 4'(v)};
        e.blank = 4'b0000; e.ovf = (v >= 10); e.due = pcyc + 5;
        q2.push_back(e);
        @(posedge clk); #1;
        iv2 = 1'b0;
    endtask

    initial begin
        exp_t m;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_bcd_out", bcd_out, 16'h0000);
        chk("rst_blank_out", blank_out, 4'b1110);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_blank2", blank2, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors
        send(0,     16'h0000, 4'b1110, 1'b0, 1'b0);
        send(1234,  16'h1234, 4'b0000, 1'b0, 1'b0);
        send(7,     16'h0007, 4'b1110, 1'b0, 1'b0);
        send(9999,  16'h9999, 4'b0000, 1'b0, 1'b0);
        send(10000, 16'h9999, 4'b0000, 1'b1, 1'b0);
        send(16383, 16'h9999, 4'b0000, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // in_valid held high, junk on bin_in during SHIFT
        send(42,    16'h0042, 4'b1100, 1'b0, 1'b1);
        send(305,   16'h0305, 4'b1000, 1'b0, 1'b1);
        send(8000,  16'h8000, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
        #1;

        // Reset mid-conversion: outputs return without a clock edge
        send(4321,  16'h4321, 4'b0000, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        q.delete();
        rst = 1'b1;
        #1;
        chk("midrst_bcd_out", bcd_out, 16'h0000);
        chk("midrst_blank_out", blank_out, 4'b1110);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        send(56,    16'h0056, 4'b1100, 1'b0, 1'b0);

        // Random sweep against the division model
        for (int n = 0; n < 30; n++) begin
            int v;
            v = int'($urandom_range(0, 16383));
            m = model(v);
            send(v, m.bcd, m.blank, m.ovf, 1'b0);
        end

        // Small instance: every value 0..15
        for (int v = 0; v < 16; v++) send2(v);

        for (int i = 0; i < 100 && (q.size() != 0 || q2.size() != 0); i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size() + q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bin_to_bcd_converter.md
# bin_to_bcd_converter

Sequential double-dabble converter that turns an unsigned binary value into packed BCD digits, one digit per display position, and feeds the per-digit data and blanking mask of the seven-segment display driver. One conversion takes BIN_BITS cycles; a valid/ready handshake on the input side and a one-cycle completion strobe on the output side let a counter, ADC or register file push values at any rate. The result register holds the last good conversion so the display refresh logic always reads stable digits.

## Interface

- NUM_DIGITS, 4, number of BCD digits produced; legal range 1..9.
- BIN_BITS, 14, width of the binary input; legal range 1..32.

- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  bin_in holds a value to convert.
- in_ready  output  1  converter idle, can accept a value this cycle.
- bin_in  input  BIN_BITS  unsigned binary value.
- bcd_out  output  4*NUM_DIGITS  packed BCD result, digit 0 (units) in bits [3:0].
- blank_out  output  NUM_DIGITS  1 = digit is a leading zero and should be blanked; bit 0 always 0.
- out_valid  output  1  one-cycle strobe: bcd_out/blank_out/overflow just updated.
- overflow  output  1  last accepted value was >= 10**NUM_DIGITS.

## Operation

- States: IDLE, SHIFT. Reset state IDLE.
- in_ready = (state == IDLE); purely combinational from state.
- Accept: rising edge with in_valid & in_ready. Capture bin_in into shift register, clear NUM_DIGITS-nibble scratch, iteration counter = 0, latch ovf_pend = (bin_in >= 10**NUM_DIGITS), go SHIFT.
- in_valid while not in_ready is ignored; bin_in not sampled.
- SHIFT, each cycle: every scratch nibble >= 5 gets +3 (4-bit, no carry between nibbles), then {scratch, shift} shifts left one bit as a single vector; counter increments.
- On the edge completing iteration BIN_BITS: write result to bcd_out, compute blank_out, write overflow = ovf_pend, assert out_valid for the next cycle, go IDLE.
- Overflow: bcd_out forced to all nibbles 4'h9, blank_out = 0, overflow = 1. Otherwise overflow = 0.
- blank_out[i] = 1 iff i > 0 and nibbles i..NUM_DIGITS-1 are all zero. Value 0 -> blank_out = all ones except bit 0.
- bcd_out, blank_out, overflow change only on completion; held between conversions.
- Comparison constant 10**NUM_DIGITS computed at elaboration in ≥ 34-bit arithmetic; when BIN_BITS is too small to reach it, overflow is constant 0.

## Timing

- Reset values: state IDLE, in_ready 1, bcd_out all 0, blank_out all ones except bit 0 (displays "0"), out_valid 0, overflow 0.
- Latency: value accepted on edge k -> out_valid high in cycle after edge k+BIN_BITS; results valid from that same edge.
- in_ready low for BIN_BITS cycles after acceptance, high again in the cycle out_valid is high.
- Back-to-back: a new value may be accepted on the edge ending the out_valid cycle; throughput one conversion per BIN_BITS+1 cycles.
- out_valid is exactly one cycle wide; no backpressure on output.
- Reset mid-conversion: conversion aborted immediately, all outputs to reset values asynchronously, no out_valid; in_ready 1 after release.
- in_valid held high continuously: a new conversion starts every BIN_BITS+1 cycles using bin_in at each accept edge.

## Test plan

- Reset, then bin_in=0 accepted -> after 14 cycles out_valid pulse, bcd_out=16'h0000, blank_out=4'b1110, overflow=0.
- bin_in=1234 -> bcd_out=16'h1234, blank_out=4'b0000; bin_in=7 -> bcd_out=16'h0007, blank_out=4'b1110; in_ready low exactly 14 cycles each.
- bin_in=9999 -> bcd_out=16'h9999, overflow=0; bin_in=10000 and 16383 -> bcd_out=16'h9999, blank_out=0, overflow=1.
- in_valid held high with values 42, 305, 8000 -> three out_valid strobes 15 cycles apart, results 16'h0042/16'h0305/16'h8000; bin_in changed during SHIFT has no effect.
- Assert rst 5 cycles into a conversion of 4321 -> outputs return to reset values without waiting for clk, no out_valid; next value 56 converts to 16'h0056.
- Random sweep over 0..16383 with NUM_DIGITS=4, BIN_BITS=14, plus NUM_DIGITS=1/BIN_BITS=4 (values 0..15) -> bcd_out, blank_out, overflow match reference model on every out_valid.
